game_sequencer: RTL and testbench
=================================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter N_LANES, default 8, number of pattern lanes sequenced.
REQ-002 Parameter LIST_LEN, default 203, number of entries in the command list.
REQ-003 Parameter SCORE_W, default 20, score and max-score width.
REQ-004 CLOCK_25  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start_btn  in  1  start request, level, active-high, already synchronous to CLOCK_25.
REQ-007 lane_done  in  N_LANES  per-lane 1-cycle pulse: lane is free and needs its next command.
REQ-008 lane_hit  in  N_LANES  per-lane 1-cycle pulse: player scored on that lane.
REQ-009 cmd_rdata  in  4  command-list read data, valid one cycle after cmd_addr.
REQ-010 cmd_addr  out  8  command-list read address.
REQ-011 lane_load  out  N_LANES  one-hot 1-cycle pulse: the addressed lane captures lane_cmd.
REQ-012 lane_cmd  out  4  command delivered with lane_load.
REQ-013 game_state  out  2  IDLE=0, PLAY=1, DRAIN=2, OVER=3.
REQ-014 score  out  SCORE_W  current-game score.
REQ-015 max_score  out  SCORE_W  best score since reset.
REQ-016 game_over  out  1  1-cycle pulse on entry to OVER.

Function
REQ-017 Start edge = start_btn high with the previous-cycle sample low; a level held high SHALL NOT retrigger.
REQ-018 IDLE->PLAY and OVER->PLAY on a start edge: score<=0, cmd_addr<=0, all N_LANES pending bits <=1, round-robin pointer <=0.
REQ-019 Start edges in PLAY or DRAIN SHALL be ignored.
REQ-020 Pending bit i SHALL set on lane_done[i] in PLAY/DRAIN; a pulse on a lane already pending has no effect.
REQ-021 Fetch engine, PLAY only: F_IDLE, where any pending bit selects a grant lane by round-robin starting at the pointer, drives cmd_addr, clears that pending bit, and moves to F_WAIT; F_WAIT drives lane_load[grant]=1 and lane_cmd=cmd_rdata, cmd_addr+1, pointer<=grant+1 mod N_LANES, and returns to F_IDLE.
REQ-022 Throughput SHALL be at most one load per 2 cycles; grant-to-load latency is exactly 1 cycle.
REQ-023 If lane_done[i] coincides with the cycle granting lane i, the set SHALL win and the bit stays pending.
REQ-024 After the load that uses address LIST_LEN-1, PLAY->DRAIN; no further reads or loads.
REQ-025 DRAIN->OVER when all N_LANES pending bits are 1; game_over pulses on that transition.
REQ-026 In PLAY/DRAIN, score SHALL add popcount(lane_hit) each cycle and saturate at 2^SCORE_W-1.
REQ-027 lane_hit and lane_done SHALL be ignored in IDLE and OVER.
REQ-028 max_score<=score on any cycle with score>max_score; max_score is never cleared by a start edge.
REQ-029 lane_load SHALL be all-zero outside F_WAIT.

Reset
REQ-030 While rst_n=0: game_state=IDLE, fetch engine=F_IDLE, pending=0, pointer=0, cmd_addr=0, lane_load=0, lane_cmd=0, score=0, max_score=0, game_over=0, edge-detect register=0.
REQ-031 Reset asserted mid-fetch SHALL abort the fetch with no lane_load pulse; after release the block waits in IDLE for a start edge.

Structure
REQ-032 Shared package holds the game_state encoding, the fetch-state encoding, and default N_LANES/LIST_LEN/SCORE_W.
REQ-033 One sub-module, rr_arbiter: pending vector plus pointer in, one-hot grant plus valid out, combinational.

Verification
REQ-034 Start edge from IDLE, lanes idle -> 8 loads to lanes 0..7 in order at cmd_addr 0..7, spaced 2 cycles apart; game_state=1.
REQ-035 lane_done on lanes 5 and 2 in the same cycle with pointer=3 -> lane 5 loaded first, then lane 2.
REQ-036 lane_hit=8'b0000_0111 for 1 cycle, then 8'b1000_0000 -> score +3, then +1; hit in OVER -> no change.
REQ-037 Score preset to 2^20-2, lane_hit with 3 bits set -> score=2^20-1.
REQ-038 LIST_LEN=10: after the 10th load -> DRAIN; all 8 lanes return done -> game_over pulse, state=3; a start edge gives score=0 with max_score unchanged.
REQ-039 rst_n low during F_WAIT -> no lane_load, all outputs at reset values; start_btn held high through reset release -> no start until low then high.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the game sequencer: state encodings and default sizes.
package game_sequencer_pkg;

    localparam int DEF_N_LANES  = 8;
    localparam int DEF_LIST_LEN = 203;
    localparam int DEF_SCORE_W  = 20;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_DRAIN = 2'd2,
        GS_OVER  = 2'd3
    } game_state_t;

    typedef enum logic {
        F_IDLE = 1'b0,
        F_WAIT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer's player/lane/command-list signals.
// The sequencer side is the master; the lanes, buttons and command memory are the slave.
interface game_sequencer_if
    import game_sequencer_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int SCORE_W = DEF_SCORE_W
);
    logic               start_btn;
    logic [N_LANES-1:0] lane_done;
    logic [N_LANES-1:0] lane_hit;
    logic [3:0]         cmd_rdata;
    logic [7:0]         cmd_addr;
    logic [N_LANES-1:0] lane_load;
    logic [3:0]         lane_cmd;
    logic [1:0]         game_state;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] max_score;
    logic               game_over;

    modport master (
        input  start_btn, lane_done, lane_hit, cmd_rdata,
        output cmd_addr, lane_load, lane_cmd, game_state, score, max_score, game_over
    );

    modport slave (
        output start_btn, lane_done, lane_hit, cmd_rdata,
        input  cmd_addr, lane_load, lane_cmd, game_state, score, max_score, game_over
    );

endinterface

// File: rtl/game_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending lane at or after ptr.
module rr_arbiter
    import game_sequencer_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int PW      = $clog2(N_LANES)
) (
    input  logic [N_LANES-1:0] pending,
    input  logic [PW-1:0]      ptr,
    output logic [N_LANES-1:0] grant,
    output logic               valid
);

    // Scan lanes ptr, ptr+1, ... wrapping at N_LANES; the first pending one wins.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < N_LANES; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_LANES)
                idx = idx - N_LANES;
            if (!valid && pending[PW'(idx)]) begin
                grant[PW'(idx)] = 1'b1;
                valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: runs a game over a command list, feeding one command per free lane,
// keeps the saturating score and the best score since reset.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int N_LANES  = DEF_N_LANES,
    parameter int LIST_LEN = DEF_LIST_LEN,
    parameter int SCORE_W  = DEF_SCORE_W
) (
    input  logic               CLOCK_25,
    input  logic               rst_n,
    game_sequencer_if.master   bus
);

    localparam int                 PW        = $clog2(N_LANES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [7:0]         LAST_ADDR = 8'(LIST_LEN - 1);

    game_state_t        state;
    fetch_state_t       fetch;
    logic [N_LANES-1:0] pending;
    logic [N_LANES-1:0] grant;
    logic [N_LANES-1:0] grant_q;
    logic [N_LANES-1:0] grant_clear;
    logic               grant_valid;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      grant_idx;
    logic [PW-1:0]      ptr_next;
    logic               start_low_q;
    logic               start_edge;
    logic               in_game;
    logic [7:0]         cmd_addr_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] max_q;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;
    logic               over_q;

    rr_arbiter #(.N_LANES(N_LANES), .PW(PW)) u_arb (
        .pending (pending),
        .ptr     (ptr),
        .grant   (grant),
        .valid   (grant_valid)
    );

    // Start edge needs the previous sample to have been low; the register resets to 0
    // so a button held through reset release cannot start a game.
    always_comb begin
        start_edge = bus.start_btn & start_low_q;
        in_game    = (state == GS_PLAY) || (state == GS_DRAIN);
    end

    // Saturating score increment by the number of hits this cycle.
    always_comb begin
        score_sum  = {1'b0, score_q} + (SCORE_W + 1)'($countones(bus.lane_hit));
        score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
    end

    // Decode the lane being loaded and the pointer value that follows it.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < N_LANES; i++) begin
            if (grant_q[i])
                grant_idx = PW'(i);
        end
        ptr_next    = (grant_idx == PW'(N_LANES - 1)) ? '0 : grant_idx + 1'b1;
        grant_clear = (state == GS_PLAY && fetch == F_IDLE && grant_valid) ? grant : '0;
    end

    // Game and fetch state machine with all game registers.
    always_ff @(posedge CLOCK_25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= GS_IDLE;
            fetch       <= F_IDLE;
            pending     <= '0;
            ptr         <= '0;
            grant_q     <= '0;
            cmd_addr_q  <= '0;
            score_q     <= '0;
            max_q       <= '0;
            over_q      <= 1'b0;
            start_low_q <= 1'b0;
        end else begin
            start_low_q <= ~bus.start_btn;
            over_q      <= 1'b0;
            if (score_q > max_q)
                max_q <= score_q;
            if (in_game)
                score_q <= score_next;
            case (state)
                GS_IDLE, GS_OVER: begin
                    if (start_edge) begin
                        state      <= GS_PLAY;
                        fetch      <= F_IDLE;
                        score_q    <= '0;
                        cmd_addr_q <= '0;
                        pending    <= '1;
                        ptr        <= '0;
                    end
                end
                GS_PLAY: begin
                    case (fetch)
                        F_IDLE: begin
                            if (grant_valid) begin
                                grant_q <= grant;
                                fetch   <= F_WAIT;
                            end
                        end
                        F_WAIT: begin
                            fetch      <= F_IDLE;
                            cmd_addr_q <= cmd_addr_q + 8'd1;
                            ptr        <= ptr_next;
                            if (cmd_addr_q == LAST_ADDR)
                                state <= GS_DRAIN;
                        end
                    endcase
                    pending <= (pending & ~grant_clear) | bus.lane_done;
                end
                GS_DRAIN: begin
                    pending <= pending | bus.lane_done;
                    if (&pending) begin
                        state  <= GS_OVER;
                        over_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_addr   = cmd_addr_q;
    assign bus.lane_load  = (fetch == F_WAIT) ? grant_q : '0;
    assign bus.lane_cmd   = (fetch == F_WAIT) ? bus.cmd_rdata : 4'd0;
    assign bus.game_state = state;
    assign bus.score      = score_q;
    assign bus.max_score  = max_q;
    assign bus.game_over  = over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a rule-level model predicts every cycle's
// status and every lane load; a separate monitor pops and compares.
module tb_game_sequencer;
    import game_sequencer_pkg::*;

    localparam int N         = 8;
    localparam int LIST_LEN  = 10;
    localparam int SCORE_W   = 6;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    typedef struct {
        int           state;
        int           score;
        int           maxScore;
        bit           over;
        int           addr;
        logic [N-1:0] load;
    } status_t;

    typedef struct {
        int lane;
        int cmd;
    } load_t;

    logic    CLOCK_25 = 1'b0;
    logic    rst_n;
    int      checks = 0;
    int      errors = 0;
    bit      monOn  = 1'b0;
    logic [3:0] mem [0:255];
    status_t statusQ[$];
    load_t   loadQ[$];

    int       mState, mPtr, mAddr, mGrant, mScore, mMax;
    bit       mBusy, mPrevLow, mOver;
    bit [N-1:0] mPend;

    game_sequencer_if #(.N_LANES(N), .SCORE_W(SCORE_W)) bus ();

    game_sequencer #(.N_LANES(N), .LIST_LEN(LIST_LEN), .SCORE_W(SCORE_W)) dut (
        .CLOCK_25 (CLOCK_25),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #20 CLOCK_25 = ~CLOCK_25;

    always @(posedge CLOCK_25) bus.cmd_rdata <= mem[bus.cmd_addr];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mState = 0; mPtr = 0; mAddr = 0; mGrant = 0; mScore = 0; mMax = 0;
        mBusy = 0; mPrevLow = 0; mOver = 0; mPend = '0;
    endtask

    task automatic pushStatus();
        status_t s;
        s.state    = mState;
        s.score    = mScore;
        s.maxScore = mMax;
        s.over     = mOver;
        s.addr     = mAddr;
        s.load     = mBusy ? (N'(1) << mGrant) : '0;
        statusQ.push_back(s);
    endtask

    task automatic modelStep(input bit start, input bit [N-1:0] done, input bit [N-1:0] hit, input bit rst);
        bit edgeSeen, found;
        int lane;
        if (!rst) begin
            modelReset();
            pushStatus();
            return;
        end
        edgeSeen = start && mPrevLow;
        mPrevLow = !start;
        mOver    = 0;
        if (mScore > mMax)
            mMax = mScore;
        if (mState == 1 || mState == 2) begin
            mScore = mScore + $countones(hit);
            if (mScore > SCORE_MAX)
                mScore = SCORE_MAX;
        end
        if (mState == 0 || mState == 3) begin
            if (edgeSeen) begin
                mState = 1; mScore = 0; mAddr = 0; mPend = '1; mPtr = 0; mBusy = 0;
            end
        end else if (mState == 1) begin
            if (mBusy) begin
                mBusy = 0;
                mPtr  = (mGrant + 1) % N;
                if (mAddr == LIST_LEN - 1)
                    mState = 2;
                mAddr++;
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    lane = (mPtr + k) % N;
                    if (!found && mPend[lane]) begin
                        found       = 1;
                        mPend[lane] = 0;
                        mBusy       = 1;
                        mGrant      = lane;
                        loadQ.push_back('{lane: lane, cmd: int'(mem[mAddr])});
                    end
                end
            end
            mPend = mPend | done;
        end else begin
            if (&mPend) begin
                mState = 3;
                mOver  = 1;
            end
            mPend = mPend | done;
        end
        pushStatus();
    endtask

    task automatic applyStimulus(input bit start, input bit [N-1:0] done, input bit [N-1:0] hit, input bit rst);
        @(negedge CLOCK_25);
        #1;
        bus.start_btn = start;
        bus.lane_done = done;
        bus.lane_hit  = hit;
        rst_n         = rst;
        modelStep(start, done, hit, rst);
    endtask

    // Monitor: every cycle compare the DUT status, and every load against the load queue.
    always @(negedge CLOCK_25) begin
        status_t e;
        load_t   l;
        if (monOn) begin
            if (statusQ.size() == 0) begin
                checkOutput("status_queue_underflow", 32'd0, 32'd1);
            end else begin
                e = statusQ.pop_front();
                checkOutput("game_state", 32'(bus.game_state), 32'(e.state));
                checkOutput("score", 32'(bus.score), 32'(e.score));
                checkOutput("max_score", 32'(bus.max_score), 32'(e.maxScore));
                checkOutput("game_over", 32'(bus.game_over), 32'(e.over));
                checkOutput("cmd_addr", 32'(bus.cmd_addr), 32'(e.addr));
                checkOutput("lane_load", 32'(bus.lane_load), 32'(e.load));
            end
            if (bus.lane_load != '0) begin
                if (loadQ.size() == 0) begin
                    checkOutput("unexpected_load", 32'(bus.lane_load), 32'd0);
                end else begin
                    l = loadQ.pop_front();
                    checkOutput("load_lane", 32'(bus.lane_load), 32'(N'(1) << l.lane));
                    checkOutput("load_cmd", 32'(bus.lane_cmd), 32'(l.cmd));
                end
            end
        end
    end

    initial begin
        bit         startLvl;
        bit [N-1:0] rd, rh;
        int         rstCnt;
        rst_n         = 1'b0;
        bus.start_btn = 1'b0;
        bus.lane_done = '0;
        bus.lane_hit  = '0;
        for (int a = 0; a < 256; a++)
            mem[a] = 4'($urandom_range(0, 15));
        modelReset();
        pushStatus();
        monOn = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 0);
        for (int i = 0; i < 2; i++) applyStimulus(0, '0, '0, 1);

        // Game 1: start, held level, two hit patterns, eight in-order loads.
        applyStimulus(1, '0, '0, 1);
        applyStimulus(1, '0, 8'b0000_0111, 1);
        applyStimulus(1, '0, 8'b1000_0000, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, 1);
        applyStimulus(1, '0, '0, 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, 1);

        // Lane 2 returns, pointer moves to 3, then lanes 5 and 2 together.
        applyStimulus(0, 8'b0000_0100, '0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 1);
        applyStimulus(0, 8'b0010_0100, '0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, '0, '0, 1);

        // Drain: every lane returns, then hits in OVER must not count.
        applyStimulus(0, 8'hFF, '0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 1);
        applyStimulus(0, '0, 8'hFF, 1);
        applyStimulus(0, '0, 8'h0F, 1);

        // Game 2 from OVER, then walk score to the saturation boundary.
        applyStimulus(1, '0, '0, 1);
        for (int i = 0; i < 200 && mScore < SCORE_MAX - 1; i++)
            applyStimulus(0, '0, 8'b0000_0001, 1);
        applyStimulus(0, '0, 8'b0000_1011, 1);
        applyStimulus(0, '0, 8'hFF, 1);
        applyStimulus(0, '0, '0, 1);

        // Reset during a fetch, with start held high through reset release.
        applyStimulus(0, 8'b0001_0000, '0, 1);
        for (int i = 0; i < 10 && !mBusy; i++) applyStimulus(0, '0, '0, 1);
        applyStimulus(1, '0, '0, 0);
        #1;
        checkOutput("abort_lane_load", 32'(bus.lane_load), 32'd0);
        checkOutput("abort_game_state", 32'(bus.game_state), 32'd0);
        checkOutput("abort_score", 32'(bus.score), 32'd0);
        checkOutput("abort_max_score", 32'(bus.max_score), 32'd0);
        applyStimulus(1, '0, '0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, '0, '0, 1);
        applyStimulus(0, '0, '0, 1);
        applyStimulus(1, '0, '0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, '0, '0, 1);

        // Random phase.
        startLvl = 1'b1;
        rstCnt   = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 9) == 0) startLvl = ~startLvl;
            for (int b = 0; b < N; b++) begin
                rd[b] = ($urandom_range(0, 3) == 0);
                rh[b] = ($urandom_range(0, 7) == 0);
            end
            if (rstCnt == 0 && $urandom_range(0, 599) == 0) rstCnt = 2;
            applyStimulus(startLvl, rd, rh, rstCnt == 0);
            if (rstCnt > 0) rstCnt--;
        end

        for (int i = 0; i < 3; i++) applyStimulus(0, '0, '0, 1);
        @(negedge CLOCK_25);
        #2;
        checkOutput("status_queue_empty", 32'(statusQ.size()), 32'd0);
        checkOutput("load_queue_empty", 32'(loadQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
